boron_job_scheduler: RTL and testbench

BORON_JOB_SCHEDULER -- requirements
Module: boron_job_scheduler

---
 rtl/boron_job_scheduler.sv | 147 ++++++++++++++
 tb/tb_boron_job_scheduler.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/boron_job_scheduler.sv
// Two-requester round-robin front end for a single shared Boron cipher engine.
// Each accepted job is launched once and waits for completion or a timeout, then held until taken.
module boron_job_scheduler #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [79:0] key,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic        req0_enc_dec,
  input  logic [63:0] req0_data,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic        req1_enc_dec,
  input  logic [63:0] req1_data,
  output logic        eng_start,
  output logic        eng_enc_dec,
  output logic [63:0] eng_data,
  output logic [79:0] eng_key,
  input  logic        eng_done,
  input  logic [63:0] eng_result,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [63:0] rsp_data,
  output logic        rsp_err,
  output logic        busy
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StLaunch, StWait, StResp} state_e;

  state_e          state_q, state_d;
  logic            last_q, last_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            enc_q, enc_d;
  logic [63:0]     data_q, data_d;
  logic [79:0]     key_q, key_d;
  logic            id_q, id_d;
  logic [63:0]     rdata_q, rdata_d;
  logic            err_q, err_d;
  logic            grant_id;
  logic            any_valid;

  // Requester not served last wins a tie.
  always_comb begin
    any_valid = req0_valid | req1_valid;
    if (req0_valid && req1_valid) begin
      grant_id = ~last_q;
    end else begin
      grant_id = req1_valid;
    end
  end

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    enc_d      = enc_q;
    data_d     = data_q;
    key_d      = key_q;
    id_d       = id_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    eng_start  = 1'b0;
    rsp_valid  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (!reset && any_valid) begin
          req0_ready = ~grant_id;
          req1_ready = grant_id;
          id_d       = grant_id;
          enc_d      = grant_id ? req1_enc_dec : req0_enc_dec;
          data_d     = grant_id ? req1_data : req0_data;
          key_d      = key;
          state_d    = StLaunch;
        end
      end
      StLaunch: begin
        eng_start = ~reset;
        cnt_d     = '0;
        state_d   = StWait;
      end
      StWait: begin
        // Completion wins over a timeout landing in the same cycle.
        if (eng_done) begin
          rdata_d = eng_result;
          err_d   = 1'b0;
          state_d = StResp;
        end else if (cnt_q == CntLast) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StResp: begin
        rsp_valid = ~reset;
        if (rsp_ready) begin
          last_d  = id_q;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      enc_q   <= 1'b0;
      data_q  <= '0;
      key_q   <= '0;
      id_q    <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      enc_q   <= enc_d;
      data_q  <= data_d;
      key_q   <= key_d;
      id_q    <= id_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign eng_enc_dec = enc_q;
  assign eng_data    = data_q;
  assign eng_key     = key_q;
  assign rsp_id      = id_q;
  assign rsp_data    = rdata_q;
  assign rsp_err     = err_q & ~reset;
  assign busy        = (state_q != StIdle) & ~reset;

endmodule

// File: tb/tb_boron_job_scheduler.sv
// Randomized bench for boron_job_scheduler: a timeline model of each job (accept, start,
// completion window, response hold) is compared with the DUT every cycle.
module tb_boron_job_scheduler;

  localparam int unsigned TO = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic [79:0] key;
  logic        req0_valid, req0_ready, req0_enc_dec;
  logic [63:0] req0_data;
  logic        req1_valid, req1_ready, req1_enc_dec;
  logic [63:0] req1_data;
  logic        eng_start, eng_enc_dec;
  logic [63:0] eng_data;
  logic [79:0] eng_key;
  logic        eng_done;
  logic [63:0] eng_result;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_err, busy;
  logic [63:0] rsp_data;

  always #5 clk = ~clk;

  boron_job_scheduler #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .key(key),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_enc_dec(req0_enc_dec),
    .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_enc_dec(req1_enc_dec),
    .req1_data(req1_data),
    .eng_start(eng_start), .eng_enc_dec(eng_enc_dec), .eng_data(eng_data), .eng_key(eng_key),
    .eng_done(eng_done), .eng_result(eng_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .busy(busy)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Job timeline model: acceptance cycle, engine latency, response cycle and payload.
  bit          m_job = 0;
  int          m_ta, m_k, m_resp_cyc;
  bit          m_resp_set = 0;
  logic [63:0] m_rdata;
  bit          m_rerr, m_id, m_enc;
  logic [63:0] m_data;
  logic [79:0] m_key;
  bit          m_last = 1;
  bit          m_zero = 0;

  // Stimulus knobs: knob_v 0=random,1=both,2=req0 only,3=none.
  int knob_v = 0, knob_k = -1, knob_pct = 100, knob_hold = 0;
  bit knob_fix = 0, knob_done_force = 0;

  int          obs_start, obs_rv, rv_count;
  bit          obs_id, obs_err;
  logic [63:0] obs_data, obs_eng_data;
  int          grants[$];

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic bound_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
  endtask

  task automatic clear_obs();
    obs_start = -1;
    obs_rv    = -1;
    rv_count  = 0;
    grants.delete();
  endtask

  task automatic step(input bit r);
    bit win, acc, e_r0, e_r1, e_busy, e_start, e_rv, in_win;
    reset = r;
    case (knob_v)
      0:       begin req0_valid = 1'($urandom); req1_valid = 1'($urandom); end
      1:       begin req0_valid = 1'b1; req1_valid = 1'b1; end
      2:       begin req0_valid = 1'b1; req1_valid = 1'b0; end
      default: begin req0_valid = 1'b0; req1_valid = 1'b0; end
    endcase
    req0_enc_dec = 1'($urandom);
    req1_enc_dec = 1'($urandom);
    req0_data    = {$urandom, $urandom};
    req1_data    = {$urandom, $urandom};
    if (knob_fix) begin
      req0_enc_dec = 1'b0;
      req0_data    = 64'h0123456789ABCDEF;
    end
    key = {$urandom, $urandom, 16'($urandom)};
    in_win = m_job && !m_resp_set && (cyc >= m_ta + 2);
    if (knob_done_force) eng_done = 1'b1;
    else if (in_win)     eng_done = (cyc == m_ta + 1 + m_k);
    else                 eng_done = ($urandom_range(0, 3) == 0);
    eng_result = knob_fix ? 64'hFEEDFACECAFEBEEF : {$urandom, $urandom};
    e_rv = !r && m_job && m_resp_set && (cyc >= m_resp_cyc);
    if (e_rv && (cyc - m_resp_cyc) < knob_hold) rsp_ready = 1'b0;
    else rsp_ready = ($urandom_range(1, 100) <= knob_pct);
    #1;

    win     = (req0_valid && req1_valid) ? ~m_last : req1_valid;
    acc     = !r && !m_job && (req0_valid || req1_valid);
    e_r0    = acc && !win;
    e_r1    = acc && win;
    e_busy  = !r && m_job;
    e_start = !r && m_job && (cyc == m_ta + 1);
    chk("req0_ready", req0_ready, e_r0);
    chk("req1_ready", req1_ready, e_r1);
    chk("busy", busy, e_busy);
    chk("eng_start", eng_start, e_start);
    chk("rsp_valid", rsp_valid, e_rv);
    if (e_rv) begin
      chk("rsp_id", rsp_id, m_id);
      chk("rsp_data", rsp_data, m_rdata);
      chk("rsp_err", rsp_err, m_rerr);
    end
    if (r) chk("rsp_err_in_reset", rsp_err, 0);
    if (!r && m_job && !m_resp_set && cyc >= m_ta + 1) begin
      chk("eng_enc_dec", eng_enc_dec, m_enc);
      chk("eng_data", eng_data, m_data);
      chk("eng_key", eng_key, m_key);
    end
    if (m_zero) begin
      chk("rst_rsp_id", rsp_id, 0);
      chk("rst_rsp_data", rsp_data, 0);
      chk("rst_eng_enc_dec", eng_enc_dec, 0);
      chk("rst_eng_data", eng_data, 0);
      chk("rst_eng_key", eng_key, 0);
    end

    if (eng_start && obs_start < 0) begin
      obs_start    = cyc;
      obs_eng_data = eng_data;
    end
    if (rsp_valid) begin
      rv_count++;
      if (obs_rv < 0) begin
        obs_rv   = cyc;
        obs_id   = rsp_id;
        obs_data = rsp_data;
        obs_err  = rsp_err;
      end
    end
    if (req0_ready && req0_valid) grants.push_back(0);
    if (req1_ready && req1_valid) grants.push_back(1);

    m_zero = r;
    if (r) begin
      m_job      = 0;
      m_resp_set = 0;
      m_last     = 1;
    end else if (!m_job) begin
      if (acc) begin
        m_job      = 1;
        m_resp_set = 0;
        m_ta       = cyc;
        m_id       = win;
        m_enc      = win ? req1_enc_dec : req0_enc_dec;
        m_data     = win ? req1_data : req0_data;
        m_key      = key;
        m_k        = (knob_k >= 0) ? knob_k : int'($urandom_range(1, 70));
      end
    end else if (!m_resp_set) begin
      if (cyc >= m_ta + 2) begin
        if (eng_done) begin
          m_resp_set = 1; m_resp_cyc = cyc + 1; m_rdata = eng_result; m_rerr = 0;
        end else if (cyc - (m_ta + 2) == TO - 1) begin
          m_resp_set = 1; m_resp_cyc = cyc + 1; m_rdata = '0; m_rerr = 1;
        end
      end
    end else if (e_rv && rsp_ready) begin
      m_last = m_id;
      m_job  = 0;
    end

    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    step(1);
    step(1);
    clear_obs();
  endtask

  initial begin
    reset = 1'b1;
    clear_obs();
    @(posedge clk);
    #1;

    // Single req0 job, engine completes after 26 cycles.
    knob_v = 2; knob_k = 26; knob_fix = 1; knob_pct = 100;
    do_reset();
    for (int i = 0; i < 100 && obs_rv < 0; i++) step(0);
    if (obs_rv < 0) bound_fail("basic_rsp");
    chk("basic_latency", 80'(obs_rv - obs_start), 27);
    chk("basic_eng_data", obs_eng_data, 64'h0123456789ABCDEF);
    chk("basic_id", obs_id, 0);
    chk("basic_data", obs_data, 64'hFEEDFACECAFEBEEF);
    chk("basic_err", obs_err, 0);
    knob_fix = 0;

    // Both requesters always valid: strict alternation starting with req0.
    knob_v = 1; knob_k = 3;
    do_reset();
    for (int i = 0; i < 200 && grants.size() < 4; i++) step(0);
    if (grants.size() < 4) bound_fail("rr_grants");
    else begin
      chk("rr_grant0", grants[0], 0);
      chk("rr_grant1", grants[1], 1);
      chk("rr_grant2", grants[2], 0);
      chk("rr_grant3", grants[3], 1);
    end

    // Engine never completes: timeout after 64 WAIT cycles, then a normal job.
    knob_v = 2; knob_k = 1000;
    do_reset();
    for (int i = 0; i < 200 && obs_rv < 0; i++) step(0);
    if (obs_rv < 0) bound_fail("timeout_rsp");
    chk("timeout_latency", 80'(obs_rv - obs_start), 65);
    chk("timeout_err", obs_err, 1);
    chk("timeout_data", obs_data, 0);
    knob_k = 5;
    for (int i = 0; i < 20; i++) step(0);

    // Response held off for 10 cycles, taken on the 11th.
    knob_v = 2; knob_k = 4; knob_hold = 10;
    do_reset();
    for (int i = 0; i < 100 && obs_rv < 0; i++) step(0);
    if (obs_rv < 0) bound_fail("hold_rsp");
    knob_v = 3;
    for (int i = 0; i < 15; i++) step(0);
    chk("hold_valid_cycles", rv_count, 11);
    knob_hold = 0;

    // Reset in WAIT followed by late done pulses: no response, req0 favoured afterwards.
    knob_v = 2; knob_k = 1000;
    do_reset();
    for (int i = 0; i < 50 && obs_start < 0; i++) step(0);
    if (obs_start < 0) bound_fail("abort_start");
    for (int i = 0; i < 5; i++) step(0);
    knob_v = 3;
    step(1);
    clear_obs();
    knob_done_force = 1;
    for (int i = 0; i < 4; i++) step(0);
    knob_done_force = 0;
    chk("abort_no_rsp", rv_count, 0);
    knob_v = 1; knob_k = 2;
    for (int i = 0; i < 20 && grants.size() < 1; i++) step(0);
    if (grants.size() < 1) bound_fail("abort_grant");
    else chk("abort_grant0", grants[0], 0);

    // Random traffic with sporadic resets and back-pressure.
    knob_v = 0; knob_k = -1; knob_pct = 70;
    for (int i = 0; i < 4000; i++) step($urandom_range(0, 299) == 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
